// File: rtl/uart_tx_buffer.sv
// Byte FIFO between mem_ctl's UART TX port and the uart_tx serializer.
// Upstream en/data/busy handshake; downstream one-cycle launch pulses paced by uart_tx_busy.
module uart_tx_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_en,
  input  logic [7:0]       in_data,
  output logic             in_busy,
  input  logic             flush,
  output logic             uart_tx_en,
  output logic [7:0]       uart_tx_data,
  input  logic             uart_tx_busy,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LVL_W-1:0] level_d;
  logic             push;
  logic             drop;
  logic             pop;
  logic             tx_en_d;
  logic [7:0]       tx_data_d;

  // Full is the registered in_busy, so a same-edge pop never makes room for a push.
  always_comb begin
    push = in_en && !in_busy && !flush;
    drop = in_en &&  in_busy && !flush;
  end

  // Launch FSM: pop in IDLE, then wait for busy to rise and fall again.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tx_en_d   = 1'b0;
    tx_data_d = uart_tx_data;
    case (state_q)
      IDLE: begin
        if (!empty && !uart_tx_busy && !flush) begin
          pop       = 1'b1;
          tx_en_d   = 1'b1;
          tx_data_d = mem[rptr_q];
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK:  if (uart_tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!uart_tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level;
    if (flush)              level_d = '0;
    else if (push && !pop)  level_d = level + LVL_W'(1);
    else if (pop && !push)  level_d = level - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      in_busy      <= 1'b0;
      overflow     <= 1'b0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      state_q      <= state_d;
      uart_tx_en   <= tx_en_d;
      uart_tx_data <= tx_data_d;
      level        <= level_d;
      empty        <= (level_d == '0);
      in_busy      <= (level_d == LVL_W'(DEPTH));
      if (push) wptr_q <= wptr_q + AW'(1);
      if (flush)    rptr_q <= wptr_q;
      else if (pop) rptr_q <= rptr_q + AW'(1);
      // A dropped push wins over a simultaneous clear.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= in_data;
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer with a simple busy-only serializer model.
module tb_uart_tx_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LVL_W = 5;

  logic             clk;
  logic             rst_n;
  logic             in_en;
  logic [7:0]       in_data;
  logic             in_busy;
  logic             flush;
  logic             uart_tx_en;
  logic [7:0]       uart_tx_data;
  logic             uart_tx_busy;
  logic [LVL_W-1:0] level;
  logic             empty;
  logic             overflow;
  logic             overflow_clr;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_en        (in_en),
    .in_data      (in_data),
    .in_busy      (in_busy),
    .flush        (flush),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .level        (level),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer stand-in: busy rises one edge after the en pulse and lasts frame_len cycles.
  int unsigned frame_len;
  logic        hold_busy;
  int unsigned busy_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              busy_cnt <= 0;
    else if (uart_tx_en)     busy_cnt <= frame_len;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = hold_busy || (busy_cnt != 0);

  int         vectors;
  int         miscompares;
  int         en_cnt;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit acc);
    in_en   = 1'b1;
    in_data = d;
    if (acc) exp_q.push_back(d);
    @(posedge clk); #1;
    in_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      if (exp_q.size() == 0 && level == '0 && !uart_tx_busy && !uart_tx_en) done = 1;
      else begin @(posedge clk); #1; n++; end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending, want 0", name, exp_q.size());
    end
    cycles(3);
  endtask

  // Monitor: every en pulse pops the scoreboard; also checks pacing and data hold.
  task automatic monitor();
    bit         prev_en   = 0;
    bit         armed     = 0;
    bit         seen_busy = 0;
    logic [7:0] last      = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 0; armed = 0; seen_busy = 0;
      end else begin
        if (int'(level) > DEPTH) begin
          vectors++; miscompares++;
          $display("FAIL level_bound: got %0d, want <= %0d", level, DEPTH);
        end
        if (armed && uart_tx_busy && uart_tx_data !== last) begin
          vectors++; miscompares++;
          $display("FAIL data_hold: got 0x%0h, want 0x%0h", uart_tx_data, last);
        end
        if (uart_tx_busy) seen_busy = 1;
        if (uart_tx_en) begin
          en_cnt++;
          vectors++;
          if (prev_en || uart_tx_busy || (armed && !seen_busy)) begin
            miscompares++;
            $display("FAIL en_pacing: got prev_en=%0b busy=%0b seen_busy=%0b, want 0/0/1",
                     prev_en, uart_tx_busy, seen_busy);
          end else if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_en: got data 0x%0h, want no pulse", uart_tx_data);
          end else begin
            e = exp_q.pop_front();
            if (uart_tx_data !== e) begin
              miscompares++;
              $display("FAIL tx_data: got 0x%0h, want 0x%0h", uart_tx_data, e);
            end
          end
          last      = uart_tx_data;
          armed     = 1;
          seen_busy = 0;
        end
        prev_en = uart_tx_en;
      end
    end
  endtask

  initial begin
    int base;
    int peak;
    int n;
    vectors = 0; miscompares = 0; en_cnt = 0;
    in_en = 0; in_data = 8'h00; flush = 0; overflow_clr = 0;
    frame_len = 4; hold_busy = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    fork monitor(); join_none
    repeat (2) @(posedge clk); #1;
    check("rst_en", uart_tx_en, 0);
    check("rst_data", uart_tx_data, 8'h00);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_in_busy", in_busy, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    cycles(2);

    // Single byte latency
    push(8'h41, 1);
    check("single_level_k", level, 1);
    check("single_empty_k", empty, 0);
    check("single_en_k", uart_tx_en, 0);
    cycles(1);
    check("single_en_k1", uart_tx_en, 1);
    check("single_data_k1", uart_tx_data, 8'h41);
    check("single_level_k1", level, 0);
    cycles(1);
    check("single_en_k2", uart_tx_en, 0);
    wait_idle("single", 100);
    check("single_empty_end", empty, 1);

    // Burst of four
    frame_len = 3;
    base = en_cnt; peak = 0;
    for (int i = 0; i < 4; i++) begin
      push(8'h30 + 8'(i), 1);
      if (int'(level) > peak) peak = int'(level);
    end
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      if (int'(level) > peak) peak = int'(level);
    end
    check("burst_peak_3_or_4", (peak >= 3 && peak <= 4), 1);
    wait_idle("burst", 200);
    check("burst_pulses", en_cnt - base, 4);

    // Full / overflow with serializer held busy
    frame_len = 2;
    hold_busy = 1;
    cycles(1);
    for (int i = 0; i < 16; i++) push(8'(i), 1);
    check("full_in_busy", in_busy, 1);
    check("full_level", level, 16);
    check("full_ovf_pre", overflow, 0);
    push(8'h10, 0);
    check("ovf_set", overflow, 1);
    check("ovf_level", level, 16);
    overflow_clr = 1; cycles(1); overflow_clr = 0;
    check("ovf_clr", overflow, 0);
    overflow_clr = 1;
    push(8'h11, 0);
    overflow_clr = 0;
    check("ovf_set_wins", overflow, 1);
    hold_busy = 0;
    wait_idle("drain16", 400);
    check("ovf_sticky", overflow, 1);
    check("drain_in_busy", in_busy, 0);
    overflow_clr = 1; cycles(1); overflow_clr = 0;
    check("ovf_clr2", overflow, 0);

    // Wrap-around with random frame lengths
    base = en_cnt;
    for (int i = 0; i < 40; i++) begin
      frame_len = $urandom_range(6, 1);
      n = 0;
      while (in_busy && n < 200) begin cycles(1); n++; end
      if (in_busy) begin
        vectors++; miscompares++;
        $display("FAIL wrap_room_timeout: got in_busy=1, want 0");
      end
      push(8'((i * 7 + 3) & 8'hFF), 1);
    end
    wait_idle("wrap", 2000);
    check("wrap_pulses", en_cnt - base, 40);

    // Flush mid-stream
    frame_len = 20;
    base = en_cnt;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i), 1);
    check("flush_first_launched", en_cnt - base, 1);
    exp_q.delete();
    flush = 1;
    push(8'hEE, 0);
    flush = 0;
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_in_busy", in_busy, 0);
    check("flush_push_no_ovf", overflow, 0);
    cycles(30);
    check("flush_no_more_en", en_cnt - base, 1);
    check("flush_frame_done", uart_tx_busy, 0);
    push(8'h77, 1);
    wait_idle("post_flush", 100);
    check("post_flush_pulse", en_cnt - base, 2);

    // Async reset while in WAIT_DONE with three queued
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1);
    check("pre_rst_level", level, 3);
    check("pre_rst_busy", uart_tx_busy, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_en", uart_tx_en, 0);
    check("mid_rst_data", uart_tx_data, 8'h00);
    check("mid_rst_level", level, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_in_busy", in_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = en_cnt;
    cycles(20);
    check("post_rst_no_en", en_cnt - base, 0);
    check("post_rst_level", level, 0);
    push(8'h55, 1);
    wait_idle("post_rst", 100);
    check("post_rst_pulse", en_cnt - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
